// File: rtl/adjmat_loader.sv
// adjmat_loader
//   Host front end for the Bellman relaxation engine. Host edge writes land in
//   a registered (NODES+1)x(NODES+1) weight matrix that feeds the engine. A run
//   is launched with a source vertex. When the engine reports done, its
//   distance vector is captured into a result buffer that the host can read.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   wr_en/wr_row/wr_col/wr_data   host edge write (IDLE only)
//   cmd_clear, cmd_run, cmd_src   host commands (IDLE only)
//   busy, err           not-IDLE indicator, sticky error flag
//   start, src          one-cycle engine start pulse and the latched source vertex
//   adjmat              weight matrix to the engine
//   eng_done, eng_vertmat   engine completion and distance vector
//   result_valid        a captured result is available
//   rd_addr, rd_data    result read port, 1-cycle registered latency
//   run_cycles          WAIT-state cycles of the last run (saturating)
module adjmat_loader #(
  parameter int                  NODES    = 16,
  parameter int                  WEIGHT_W = 32,
  parameter logic [WEIGHT_W-1:0] INF      = 32'h0000FFFF
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  wr_en,
  input  logic [6:0]                            wr_row,
  input  logic [6:0]                            wr_col,
  input  logic [WEIGHT_W-1:0]                   wr_data,
  input  logic                                  cmd_clear,
  input  logic                                  cmd_run,
  input  logic [6:0]                            cmd_src,
  output logic                                  busy,
  output logic                                  err,
  output logic                                  start,
  output logic [6:0]                            src,
  output logic [NODES:0][NODES:0][WEIGHT_W-1:0] adjmat,
  input  logic                                  eng_done,
  input  logic [NODES:0][WEIGHT_W-1:0]          eng_vertmat,
  output logic                                  result_valid,
  input  logic [6:0]                            rd_addr,
  output logic [WEIGHT_W-1:0]                   rd_data,
  output logic [31:0]                           run_cycles
);

  localparam int               IDX_W    = $clog2(NODES + 1);
  localparam logic [6:0]       MAX_IDX  = 7'(NODES);
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(NODES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_START,
    S_ARM,
    S_WAIT,
    S_CAPTURE
  } state_t;

  state_t                               r_state;
  state_t                               w_state_next;
  logic [IDX_W-1:0]                     r_row;
  logic [6:0]                           r_src;
  logic                                 r_err;
  logic                                 r_result_valid;
  logic [31:0]                          r_run_cycles;
  logic [WEIGHT_W-1:0]                  r_result [0:NODES];
  logic [WEIGHT_W-1:0]                  r_rd_data;
  logic [NODES:0][NODES:0][WEIGHT_W-1:0] r_adjmat;

  logic             w_wr_ok;
  logic             w_src_ok;
  logic             w_rd_ok;
  logic             w_any_cmd;
  logic [IDX_W-1:0] w_wr_row;
  logic [IDX_W-1:0] w_wr_col;
  logic [IDX_W-1:0] w_rd_idx;

  assign w_wr_ok   = wr_en && (wr_row <= MAX_IDX) && (wr_col <= MAX_IDX);
  assign w_src_ok  = (cmd_src <= MAX_IDX);
  assign w_rd_ok   = (rd_addr <= MAX_IDX);
  assign w_any_cmd = wr_en | cmd_clear | cmd_run;
  // Truncated indices are only used after the corresponding range check.
  assign w_wr_row  = wr_row[IDX_W-1:0];
  assign w_wr_col  = wr_col[IDX_W-1:0];
  assign w_rd_idx  = rd_addr[IDX_W-1:0];

  // Next-state and state-decoded outputs
  always_comb begin
    w_state_next = r_state;
    busy         = (r_state != S_IDLE);
    start        = (r_state == S_START);
    case (r_state)
      S_IDLE: begin
        // Clear has priority over run when both arrive together.
        if (cmd_clear)                w_state_next = S_CLEAR;
        else if (cmd_run && w_src_ok) w_state_next = S_START;
      end
      S_CLEAR:   if (r_row == LAST_ROW) w_state_next = S_IDLE;
      S_START:   w_state_next = S_ARM;
      // The engine's done from a previous run is stale until it has seen start.
      S_ARM:     w_state_next = S_WAIT;
      S_WAIT:    if (eng_done) w_state_next = S_CAPTURE;
      S_CAPTURE: w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Control registers, result buffer and read port
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_CLEAR;
      r_row          <= '0;
      r_src          <= '0;
      r_err          <= 1'b0;
      r_result_valid <= 1'b0;
      r_run_cycles   <= '0;
      r_rd_data      <= '0;
      for (int i = 0; i <= NODES; i++) r_result[i] <= '0;
    end else begin
      r_state   <= w_state_next;
      // Read port runs every cycle; a read on the capture edge sees the old value.
      r_rd_data <= w_rd_ok ? r_result[w_rd_idx] : '0;
      case (r_state)
        S_IDLE: begin
          if (cmd_clear) begin
            r_row <= '0;
            // Accepted clear clears err, unless it swallowed a run request.
            r_err <= cmd_run;
          end else begin
            if (wr_en && !w_wr_ok) r_err <= 1'b1;
            if (cmd_run) begin
              if (w_src_ok) begin
                r_src          <= cmd_src;
                r_result_valid <= 1'b0;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
        end
        S_CLEAR: begin
          r_row <= (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
          if (w_any_cmd) r_err <= 1'b1;
        end
        S_START: begin
          r_run_cycles <= '0;
          if (w_any_cmd) r_err <= 1'b1;
        end
        S_WAIT: begin
          if (r_run_cycles != 32'hFFFF_FFFF) r_run_cycles <= r_run_cycles + 32'd1;
          if (w_any_cmd) r_err <= 1'b1;
        end
        S_CAPTURE: begin
          for (int i = 0; i <= NODES; i++) r_result[i] <= eng_vertmat[i];
          r_result_valid <= 1'b1;
          if (w_any_cmd) r_err <= 1'b1;
        end
        default: begin
          if (w_any_cmd) r_err <= 1'b1;
        end
      endcase
    end
  end

  // Weight matrix: not reset directly; the CLEAR sweep that follows reset
  // rewrites every row. Only CLEAR and IDLE modify it, so it is stable while
  // the engine runs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == S_CLEAR) begin
        for (int c = 0; c <= NODES; c++)
          r_adjmat[r_row][c] <= (r_row == IDX_W'(c)) ? '0 : INF;
      end else if (r_state == S_IDLE && !cmd_clear && w_wr_ok) begin
        r_adjmat[w_wr_row][w_wr_col] <= wr_data;
      end
    end
  end

  assign err          = r_err;
  assign src          = r_src;
  assign adjmat       = r_adjmat;
  assign result_valid = r_result_valid;
  assign rd_data      = r_rd_data;
  assign run_cycles   = r_run_cycles;

endmodule

// File: tb/tb_adjmat_loader.sv
// Self-checking bench for adjmat_loader: a table of edge writes, hand-built
// run sequences for the multi-cycle corner cases, and randomized runs against
// a behavioural model of the matrix, error flag and result buffer.
module tb_adjmat_loader;

  localparam int          NODES = 16;
  localparam logic [31:0] INF   = 32'h0000FFFF;

  logic                           clk = 1'b0;
  logic                           reset;
  logic                           wr_en;
  logic [6:0]                     wr_row;
  logic [6:0]                     wr_col;
  logic [31:0]                    wr_data;
  logic                           cmd_clear;
  logic                           cmd_run;
  logic [6:0]                     cmd_src;
  logic                           busy;
  logic                           err;
  logic                           start;
  logic [6:0]                     src;
  logic [NODES:0][NODES:0][31:0]  adjmat;
  logic                           eng_done;
  logic [NODES:0][31:0]           eng_vertmat;
  logic                           result_valid;
  logic [6:0]                     rd_addr;
  logic [31:0]                    rd_data;
  logic [31:0]                    run_cycles;

  adjmat_loader #(.NODES(NODES), .WEIGHT_W(32), .INF(INF)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .cmd_clear(cmd_clear), .cmd_run(cmd_run), .cmd_src(cmd_src),
    .busy(busy), .err(err), .start(start), .src(src), .adjmat(adjmat),
    .eng_done(eng_done), .eng_vertmat(eng_vertmat),
    .result_valid(result_valid), .rd_addr(rd_addr), .rd_data(rd_data),
    .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int n_runs   = 0;

  // Behavioural model
  logic [31:0] m_adj [0:NODES][0:NODES];
  logic [31:0] m_res [0:NODES];
  logic        m_err;

  typedef struct {
    logic [6:0]  row;
    logic [6:0]  col;
    logic [31:0] data;
    logic        exp_err;
  } wvec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r <= NODES; r++)
      for (int c = 0; c <= NODES; c++)
        m_adj[r][c] = (r == c) ? 32'd0 : INF;
  endtask

  task automatic model_write(input logic [6:0] row, input logic [6:0] col, input logic [31:0] data);
    if (row <= 7'd16 && col <= 7'd16) m_adj[row][col] = data;
    else m_err = 1'b1;
  endtask

  task automatic chk_matrix(input string name);
    int bad = 0;
    for (int r = 0; r <= NODES; r++)
      for (int c = 0; c <= NODES; c++)
        if (adjmat[r][c] !== m_adj[r][c]) bad++;
    chk(name, bad, 0);
  endtask

  task automatic write_edge(input logic [6:0] row, input logic [6:0] col, input logic [31:0] data);
    wr_en = 1'b1; wr_row = row; wr_col = col; wr_data = data;
    model_write(row, col, data);
    tick();
    wr_en = 1'b0;
    $display("write (%0d,%0d)=%h err=%0b", row, col, data, err);
  endtask

  // Issue cmd_clear (optionally with a colliding cmd_run) and measure the sweep.
  task automatic clear_and_count(input logic with_run);
    int busy_cnt;
    int starts;
    cmd_clear = 1'b1; cmd_run = with_run; cmd_src = 7'd1;
    tick();
    cmd_clear = 1'b0; cmd_run = 1'b0;
    model_clear();
    m_err = with_run;
    busy_cnt = int'(busy);
    starts   = int'(start);
    for (int i = 0; i < 20; i++) begin
      tick();
      busy_cnt += int'(busy);
      starts   += int'(start);
    end
    chk("sweep_busy_cycles", busy_cnt, 17);
    chk("sweep_no_start", starts, 0);
    chk("sweep_err", err, m_err);
    chk_matrix("sweep_matrix");
    $display("clear with_run=%0b busy_cycles=%0d err=%0b", with_run, busy_cnt, err);
  endtask

  // One run against an inline engine model: the engine observes start at edge
  // E0 and raises done after edge E_m, so WAIT lasts m cycles. With 'stale'
  // the engine still holds done from before and drops it after E1.
  task automatic do_run(input logic [6:0] s, input int m, input logic stale,
                        input int inject, input logic [6:0] raddr);
    logic [31:0] newv [0:NODES];
    int starts;
    for (int i = 0; i <= NODES; i++) begin
      newv[i]        = $urandom;
      eng_vertmat[i] = newv[i];
    end
    eng_done = stale;
    if (wr_en) model_write(wr_row, wr_col, wr_data);
    cmd_run = 1'b1; cmd_src = s;
    tick();
    cmd_run = 1'b0; wr_en = 1'b0;
    starts = int'(start);
    chk("run_accepted_busy", busy, 1'b1);
    chk("run_rv_cleared", result_valid, 1'b0);
    chk("run_src", src, s);
    tick();
    starts += int'(start);
    for (int k = 1; k <= m; k++) begin
      if (k == inject) begin
        wr_en = 1'b1; wr_row = 7'd2; wr_col = 7'd3; wr_data = 32'd7; cmd_clear = 1'b1;
      end
      tick();
      starts += int'(start);
      if (k == inject) begin
        wr_en = 1'b0; cmd_clear = 1'b0;
        m_err = 1'b1;
        chk("wait_cmd_err", err, 1'b1);
      end
      if (k == 1) eng_done = 1'b0;
      if (k == 2) begin
        chk("no_early_capture_busy", busy, 1'b1);
        chk("no_early_capture_rv", result_valid, 1'b0);
      end
      if (k == m) begin
        eng_done = 1'b1;
        chk_matrix("held_matrix");
      end
    end
    rd_addr = raddr;
    tick();
    chk("capture_pending_rv", result_valid, 1'b0);
    tick();
    chk("rd_during_capture", rd_data, m_res[raddr]);
    chk("result_valid", result_valid, 1'b1);
    chk("idle_after_run", busy, 1'b0);
    chk("run_cycles", run_cycles, 32'(m));
    chk("start_pulses", starts, 1);
    chk("run_err", err, m_err);
    m_res = newv;
    tick();
    chk("rd_after_capture", rd_data, m_res[raddr]);
    n_runs++;
    $display("run %0d: src=%0d wait=%0d stale=%0b run_cycles=%0d rd[%0d]=%h",
             n_runs, s, m, stale, run_cycles, raddr, rd_data);
  endtask

  task automatic chk_reads();
    for (int a = 0; a <= 20; a++) begin
      rd_addr = 7'(a);
      tick();
      chk("rd_data", rd_data, (a <= NODES) ? m_res[a] : 32'd0);
    end
  endtask

  initial begin
    wvec_t wtab [8];
    int    busy_cnt;
    int    starts;

    wtab[0] = '{row: 7'd5,   col: 7'd6,   data: 32'h0000_1234, exp_err: 1'b0};
    wtab[1] = '{row: 7'd16,  col: 7'd16,  data: 32'd77,        exp_err: 1'b0};
    wtab[2] = '{row: 7'd0,   col: 7'd16,  data: 32'hDEAD_BEEF, exp_err: 1'b0};
    wtab[3] = '{row: 7'd16,  col: 7'd0,   data: 32'd0,         exp_err: 1'b0};
    wtab[4] = '{row: 7'd17,  col: 7'd0,   data: 32'd9,         exp_err: 1'b1};
    wtab[5] = '{row: 7'd0,   col: 7'd17,  data: 32'd9,         exp_err: 1'b1};
    wtab[6] = '{row: 7'd5,   col: 7'd6,   data: 32'h55,        exp_err: 1'b1};
    wtab[7] = '{row: 7'd127, col: 7'd127, data: 32'd1,         exp_err: 1'b1};

    reset = 1'b1; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
    cmd_clear = 1'b0; cmd_run = 1'b0; cmd_src = '0; eng_done = 1'b0;
    eng_vertmat = '0; rd_addr = '0;
    for (int i = 0; i <= NODES; i++) m_res[i] = 32'd0;
    m_err = 1'b0;
    model_clear();

    // Reset state
    repeat (3) tick();
    chk("reset_start", start, 1'b0);
    chk("reset_err", err, 1'b0);
    chk("reset_rv", result_valid, 1'b0);
    chk("reset_run_cycles", run_cycles, 32'd0);
    chk("reset_rd_data", rd_data, 32'd0);
    chk("reset_src", src, 7'd0);
    chk("reset_busy", busy, 1'b1);

    // Post-reset sweep
    reset = 1'b0;
    busy_cnt = int'(busy);
    for (int i = 0; i < 20; i++) begin
      tick();
      busy_cnt += int'(busy);
    end
    chk("reset_sweep_busy", busy_cnt, 17);
    chk("adj_3_3", adjmat[3][3], 32'd0);
    chk("adj_3_4", adjmat[3][4], INF);
    chk_matrix("reset_matrix");
    chk("post_reset_err", err, 1'b0);
    chk("post_reset_rv", result_valid, 1'b0);

    // Table-driven edge writes
    for (int i = 0; i < 8; i++) begin
      write_edge(wtab[i].row, wtab[i].col, wtab[i].data);
      chk("wtab_err", err, wtab[i].exp_err);
      if (wtab[i].row <= 7'd16 && wtab[i].col <= 7'd16)
        chk("wtab_cell", adjmat[wtab[i].row][wtab[i].col], wtab[i].data);
      chk_matrix("wtab_matrix");
    end
    clear_and_count(1'b0);

    // Basic run; the last edge write coincides with cmd_run
    write_edge(7'd0, 7'd1, 32'd5);
    write_edge(7'd1, 7'd2, 32'd3);
    wr_en = 1'b1; wr_row = 7'd0; wr_col = 7'd2; wr_data = 32'd10;
    do_run(7'd0, 40, 1'b0, 0, 7'd2);
    chk("adj_0_2_run_write", adjmat[0][2], 32'd10);

    // Stale done from the previous run
    do_run(7'd3, 10, 1'b1, 0, 7'd5);

    // Host activity during WAIT is ignored but flagged
    do_run(7'd1, 30, 1'b0, 5, 7'd3);
    chk("adj_2_3_untouched", adjmat[2][3], m_adj[2][3]);
    clear_and_count(1'b0);

    // Clear and run together: clear wins
    clear_and_count(1'b1);
    clear_and_count(1'b0);
    write_edge(7'd20, 7'd1, 32'd42);
    chk("oob_write_err", err, 1'b1);
    chk_matrix("oob_write_matrix");
    clear_and_count(1'b0);
    cmd_run = 1'b1; cmd_src = 7'd17;
    tick();
    cmd_run = 1'b0;
    m_err = 1'b1;
    chk("bad_src_busy", busy, 1'b0);
    chk("bad_src_err", err, 1'b1);
    chk("bad_src_start", start, 1'b0);
    clear_and_count(1'b0);

    // Randomized writes and runs
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++)
        write_edge(7'($urandom_range(0, 18)), 7'($urandom_range(0, 18)), $urandom);
      chk("rand_err", err, m_err);
      chk_matrix("rand_matrix");
      do_run(7'($urandom_range(0, 16)), int'($urandom_range(2, 40)),
             1'($urandom_range(0, 1)), 0, 7'($urandom_range(0, 16)));
      if (m_err) clear_and_count(1'b0);
    end
    chk_reads();

    // Reset during WAIT
    eng_done = 1'b0;
    cmd_run = 1'b1; cmd_src = 7'd2;
    tick();
    cmd_run = 1'b0;
    tick();
    for (int k = 1; k <= 6; k++) tick();
    chk("mid_wait_busy", busy, 1'b1);
    chk("mid_wait_cycles", run_cycles, 32'd5);
    reset = 1'b1;
    tick();
    for (int i = 0; i <= NODES; i++) m_res[i] = 32'd0;
    m_err = 1'b0;
    model_clear();
    chk("midrst_start", start, 1'b0);
    chk("midrst_rv", result_valid, 1'b0);
    chk("midrst_run_cycles", run_cycles, 32'd0);
    chk("midrst_rd_data", rd_data, 32'd0);
    chk("midrst_busy", busy, 1'b1);
    eng_done = 1'b1;
    reset = 1'b0;
    busy_cnt = int'(busy);
    starts   = int'(start);
    for (int i = 0; i < 20; i++) begin
      tick();
      busy_cnt += int'(busy);
      starts   += int'(start);
    end
    chk("midrst_sweep_busy", busy_cnt, 17);
    chk("midrst_no_start", starts, 0);
    chk("midrst_rv_after", result_valid, 1'b0);
    chk("midrst_err_after", err, 1'b0);
    chk_matrix("midrst_matrix");
    chk_reads();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/adjmat_loader.md
Name: adjmat_loader

Overview:
- Host-facing front end for the Bellman relaxation engine, i.e. the writer side of the engine's adjacency-matrix/distance interface.
- Accepts edge-weight writes from the host bus into a registered (NODES+1)x(NODES+1) matrix that drives the engine's adjmat input.
- Launches a run with a chosen source vertex, waits for done, and captures the distance vector into a host-readable result buffer with a cycle count.

Parameters:
NODES, 16, highest vertex index; matrix and vector span indices 0..NODES
WEIGHT_W, 32, edge weight / distance width
INF, 32'h0000FFFF, "no edge" weight written by clear

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  host edge write strobe
wr_row  in  7  source vertex of edge
wr_col  in  7  destination vertex of edge
wr_data  in  WEIGHT_W  edge weight
cmd_clear  in  1  request matrix clear (pulse)
cmd_run  in  1  request run (pulse)
cmd_src  in  7  source vertex, sampled with cmd_run
busy  out  1  high in any state other than IDLE
err  out  1  sticky error flag, cleared by accepted cmd_clear or reset
start  out  1  one-cycle start pulse to engine
src  out  7  source vertex to engine, held stable from START until the next accepted run
adjmat  out  WEIGHT_W x (NODES+1)x(NODES+1)  matrix to engine
eng_done  in  1  engine done
eng_vertmat  in  WEIGHT_W x (NODES+1)  engine distance vector
result_valid  out  1  high once a result is captured; cleared on the cycle a run is accepted
rd_addr  in  7  result vertex index
rd_data  out  WEIGHT_W  result[rd_addr], registered, 1-cycle latency; 0 if rd_addr > NODES
run_cycles  out  32  cycles spent in WAIT for the last run

Behaviour:
- States: IDLE, CLEAR, START, ARM, WAIT, CAPTURE.
- Reset:
  - state=CLEAR, row counter=0, start=0, src=0, err=0, result_valid=0, run_cycles=0, result buffer all 0, rd_data=0.
  - Matrix is not reset directly; the CLEAR sweep rewrites it.
- CLEAR:
  - Writes one row per cycle: entry [r][c] = 0 if r==c, else INF.
  - Row counter increments; after row NODES is written, go to IDLE. Duration is exactly NODES+1 cycles.
  - Entered from reset or from IDLE on cmd_clear.
- IDLE:
  - wr_en with wr_row<=NODES and wr_col<=NODES writes adjmat[wr_row][wr_col]=wr_data at that edge.
  - Out-of-range index: write dropped, err=1.
- IDLE command handling:
  - cmd_run with cmd_src<=NODES: latch src, clear result_valid, go to START.
  - cmd_run with cmd_src>NODES: ignored, err=1.
  - cmd_clear and cmd_run in the same cycle: clear wins, run dropped, err=1.
  - wr_en together with an accepted cmd_run: the write is applied, and the run sees it because the matrix is registered before start is observed.
  - wr_en together with cmd_clear: the write is dropped (clear overwrites), no err.
- Non-IDLE states: wr_en, cmd_clear and cmd_run are ignored and set err=1.
- START: start=1 for exactly this cycle; run_cycles counter cleared; go to ARM.
- ARM: one cycle in which eng_done is ignored, since the engine's previous done is stale until it observes start; go to WAIT.
- WAIT:
  - run_cycles increments every cycle and saturates at 32'hFFFFFFFF.
  - eng_done==1 goes to CAPTURE.
  - There is no timeout; reset is the only exit other than done.
- CAPTURE: result buffer <= eng_vertmat (all entries); result_valid=1; go to IDLE. Total latency from cmd_run to result_valid is run_cycles+4 cycles.
- Reading: rd_data updates every cycle from the result buffer regardless of state. A read issued during the CAPTURE edge returns the old value.
- Reset mid-run: start deasserts immediately, the engine result is discarded, and a CLEAR sweep follows.
- adjmat outputs are held constant from START until IDLE is re-entered.

Test Plan:
- Reset, then hold 20 cycles -> busy high for exactly 17 cycles; adjmat[3][3]=0, adjmat[3][4]=32'h0000FFFF; err=0, result_valid=0.
- Write (0,1)=5, (1,2)=3, (0,2)=10; cmd_run src=0 against an engine model asserting done 40 cycles after start -> start pulses exactly once; result_valid rises; run_cycles=40; reading addr 2 returns the model's vertmat[2] one cycle later.
- Stale done: model holds eng_done=1 from a previous run, drops it 1 cycle after start, reasserts 10 cycles later -> capture happens only on the reassertion; run_cycles=10 counted after ARM.
- During WAIT: assert wr_en (2,3)=7 and cmd_clear -> adjmat unchanged; err=1; run completes normally. Then cmd_clear in IDLE -> err=0, 17-cycle sweep.
- Same-cycle cmd_clear+cmd_run in IDLE -> CLEAR entered, no start pulse, err=1. Also wr_en to row 20 -> dropped, err=1.
- Reset asserted 5 cycles into WAIT -> start=0; result_valid=0; CLEAR sweep restarts from row 0; a late eng_done is ignored.
